// File: rtl/bht_btb_predictor.sv
// bht_btb_predictor: direct-mapped BTB with 2-bit counters, bimodal or gshare indexed
module bht_btb_predictor #(
    parameter int INDEX_BITS = 5,
    parameter int TAG_BITS   = 8,
    parameter int HIST_BITS  = 5,
    parameter int MODE       = 0,
    parameter int WIDTH      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_if_pc,
    output logic             o_pred_taken,
    output logic [WIDTH-1:0] o_pred_target,
    input  logic             i_upd_valid,
    input  logic [WIDTH-1:0] i_upd_pc,
    input  logic             i_upd_uncond,
    input  logic             i_upd_taken,
    input  logic [WIDTH-1:0] i_upd_target,
    input  logic             i_upd_pred_taken,
    input  logic [WIDTH-1:0] i_upd_pred_target,
    output logic             o_mispredict,
    output logic [15:0]      o_hit_count,
    output logic [15:0]      o_mispred_count
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [ENTRIES-1:0]    r_valid;
    logic [ENTRIES-1:0]    r_uncond;
    logic [TAG_BITS-1:0]   r_tag [ENTRIES];
    logic [WIDTH-1:0]      r_target [ENTRIES];
    logic [1:0]            r_ctr [ENTRIES];
    logic [HIST_BITS-1:0]  r_ghr;
    logic [15:0]           r_hit_count;
    logic [15:0]           r_mispred_count;
    logic [INDEX_BITS-1:0] w_hist;
    logic [INDEX_BITS-1:0] w_lidx;
    logic [INDEX_BITS-1:0] w_lcidx;
    logic [INDEX_BITS-1:0] w_uidx;
    logic [INDEX_BITS-1:0] w_ucidx;
    logic [TAG_BITS-1:0]   w_ltag;
    logic [TAG_BITS-1:0]   w_utag;
    logic [1:0]            w_uctr;
    logic                  w_hit;

    assign w_hist  = (MODE == 1) ? INDEX_BITS'(r_ghr) : '0;
    assign w_lidx  = i_if_pc[INDEX_BITS:1];
    assign w_ltag  = i_if_pc[INDEX_BITS+TAG_BITS:INDEX_BITS+1];
    assign w_lcidx = w_lidx ^ w_hist;
    assign w_uidx  = i_upd_pc[INDEX_BITS:1];
    assign w_utag  = i_upd_pc[INDEX_BITS+TAG_BITS:INDEX_BITS+1];
    assign w_ucidx = w_uidx ^ w_hist;

    assign o_hit_count     = r_hit_count;
    assign o_mispred_count = r_mispred_count;

    // Zero-latency fetch lookup; an invalid entry masks the unreset tag/target/uncond storage
    always_comb begin
        w_hit         = r_valid[w_lidx] && (r_tag[w_lidx] == w_ltag);
        o_pred_taken  = w_hit && (r_uncond[w_lidx] || r_ctr[w_lcidx][1]);
        o_pred_target = w_hit ? r_target[w_lidx] : '0;
    end

    // Resolution check and saturating next value of the trained counter
    always_comb begin
        o_mispredict = i_upd_valid && ((i_upd_taken != i_upd_pred_taken) ||
                       (i_upd_taken && (i_upd_pred_target != i_upd_target)));
        w_uctr = i_upd_taken ? ((r_ctr[w_ucidx] == 2'b11) ? 2'b11 : r_ctr[w_ucidx] + 2'b01)
                             : ((r_ctr[w_ucidx] == 2'b00) ? 2'b00 : r_ctr[w_ucidx] - 2'b01);
    end

    // Control state: valid bits, counters, history and performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid         <= '0;
            r_ghr           <= '0;
            r_hit_count     <= '0;
            r_mispred_count <= '0;
            for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= 2'b01;
        end else begin
            if (i_upd_valid && i_upd_taken) r_valid[w_uidx] <= 1'b1;
            if (i_upd_valid && !i_upd_uncond) r_ctr[w_ucidx] <= w_uctr;
            if (MODE == 1 && i_upd_valid && !i_upd_uncond) r_ghr <= {r_ghr[HIST_BITS-2:0], i_upd_taken};
            if (o_pred_taken && r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
            if (o_mispredict && r_mispred_count != 16'hFFFF) r_mispred_count <= r_mispred_count + 16'd1;
        end
    end

    // Entry payload is written only on taken outcomes and needs no reset
    always_ff @(posedge clk) begin
        if (i_upd_valid && i_upd_taken) begin
            r_tag[w_uidx]    <= w_utag;
            r_target[w_uidx] <= i_upd_target;
            r_uncond[w_uidx] <= i_upd_uncond;
        end
    end
endmodule

// File: tb/tb_bht_btb_predictor.sv
// tb_bht_btb_predictor: directed checks of a bimodal and a gshare predictor instance
module tb_bht_btb_predictor;
    localparam logic [15:0] NEUTRAL = 16'h0002;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] if_pc [2];
    logic        pred_taken [2];
    logic [15:0] pred_target [2];
    logic        upd_valid [2];
    logic [15:0] upd_pc [2];
    logic        upd_uncond [2];
    logic        upd_taken [2];
    logic [15:0] upd_target [2];
    logic        upd_pred_taken [2];
    logic [15:0] upd_pred_target [2];
    logic        mispredict [2];
    logic [15:0] hit_count [2];
    logic [15:0] mispred_count [2];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    bht_btb_predictor #(.MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .i_if_pc(if_pc[0]),
        .o_pred_taken(pred_taken[0]), .o_pred_target(pred_target[0]),
        .i_upd_valid(upd_valid[0]), .i_upd_pc(upd_pc[0]), .i_upd_uncond(upd_uncond[0]),
        .i_upd_taken(upd_taken[0]), .i_upd_target(upd_target[0]),
        .i_upd_pred_taken(upd_pred_taken[0]), .i_upd_pred_target(upd_pred_target[0]),
        .o_mispredict(mispredict[0]), .o_hit_count(hit_count[0]), .o_mispred_count(mispred_count[0])
    );

    bht_btb_predictor #(.MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .i_if_pc(if_pc[1]),
        .o_pred_taken(pred_taken[1]), .o_pred_target(pred_target[1]),
        .i_upd_valid(upd_valid[1]), .i_upd_pc(upd_pc[1]), .i_upd_uncond(upd_uncond[1]),
        .i_upd_taken(upd_taken[1]), .i_upd_target(upd_target[1]),
        .i_upd_pred_taken(upd_pred_taken[1]), .i_upd_pred_target(upd_pred_target[1]),
        .o_mispredict(mispredict[1]), .o_hit_count(hit_count[1]), .o_mispred_count(mispred_count[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic look(input int s, input logic [15:0] pc, input logic exp_pt, input logic [15:0] exp_tg);
        if_pc[s] = pc;
        #1;
        check($sformatf("pred_taken[%0d] pc=%h", s, pc), 32'(pred_taken[s]), 32'(exp_pt));
        check($sformatf("pred_target[%0d] pc=%h", s, pc), 32'(pred_target[s]), 32'(exp_tg));
        if_pc[s] = NEUTRAL;
    endtask

    task automatic upd(input int s, input logic [15:0] pc, input logic unc, input logic tk,
                       input logic [15:0] tg, input logic ptk, input logic [15:0] ptg, input logic exp_mp);
        upd_valid[s]       = 1'b1;
        upd_pc[s]          = pc;
        upd_uncond[s]      = unc;
        upd_taken[s]       = tk;
        upd_target[s]      = tg;
        upd_pred_taken[s]  = ptk;
        upd_pred_target[s] = ptg;
        #1;
        check($sformatf("mispredict[%0d] pc=%h", s, pc), 32'(mispredict[s]), 32'(exp_mp));
        @(posedge clk);
        #1;
        upd_valid[s] = 1'b0;
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            if_pc[s] = NEUTRAL;
            upd_valid[s] = 1'b0;
            upd_pc[s] = '0;
            upd_uncond[s] = 1'b0;
            upd_taken[s] = 1'b0;
            upd_target[s] = '0;
            upd_pred_taken[s] = 1'b0;
            upd_pred_target[s] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        look(0, 16'h0040, 1'b0, 16'h0000);
        check("hit_count[0] after reset", 32'(hit_count[0]), 32'd0);
        check("mispred_count[0] after reset", 32'(mispred_count[0]), 32'd0);
        // Bimodal: train 0x0040 taken twice (01->10->11)
        upd(0, 16'h0040, 1'b0, 1'b1, 16'h0020, 1'b0, 16'h0000, 1'b1);
        upd(0, 16'h0040, 1'b0, 1'b1, 16'h0020, 1'b1, 16'h0020, 1'b0);
        if_pc[0] = 16'h0040;
        #1;
        check("pred_taken[0] trained", 32'(pred_taken[0]), 32'd1);
        check("pred_target[0] trained", 32'(pred_target[0]), 32'h0020);
        @(posedge clk);
        #1;
        if_pc[0] = NEUTRAL;
        check("hit_count[0] after hit cycle", 32'(hit_count[0]), 32'd1);
        // Not-taken twice (11->10->01), then saturate at 00
        upd(0, 16'h0040, 1'b0, 1'b0, 16'h0020, 1'b1, 16'h0020, 1'b1);
        look(0, 16'h0040, 1'b1, 16'h0020);
        upd(0, 16'h0040, 1'b0, 1'b0, 16'h0020, 1'b1, 16'h0020, 1'b1);
        look(0, 16'h0040, 1'b0, 16'h0020);
        upd(0, 16'h0040, 1'b0, 1'b0, 16'h1234, 1'b0, 16'h0020, 1'b0);
        upd(0, 16'h0040, 1'b0, 1'b0, 16'h0020, 1'b0, 16'h0020, 1'b0);
        check("ctr[0] saturated low", 32'(u0.r_ctr[0]), 32'd0);
        look(0, 16'h0040, 1'b0, 16'h0020);
        // JSR at 0x0100 (same index) with a target mismatch; predicted taken despite ctr=00
        upd(0, 16'h0100, 1'b1, 1'b1, 16'h0300, 1'b1, 16'h0200, 1'b1);
        look(0, 16'h0100, 1'b1, 16'h0300);
        look(0, 16'h0040, 1'b0, 16'h0000);
        check("ctr[0] untouched by JSR", 32'(u0.r_ctr[0]), 32'd0);
        // Alias 0x0080: miss, then taken updates overwrite the entry (00->01->10)
        look(0, 16'h0080, 1'b0, 16'h0000);
        upd(0, 16'h0080, 1'b0, 1'b1, 16'h0500, 1'b0, 16'h0000, 1'b1);
        look(0, 16'h0080, 1'b0, 16'h0500);
        upd(0, 16'h0080, 1'b0, 1'b1, 16'h0500, 1'b0, 16'h0000, 1'b1);
        look(0, 16'h0080, 1'b1, 16'h0500);
        look(0, 16'h0100, 1'b0, 16'h0000);
        check("ghr[0] unchanged in bimodal", 32'(u0.r_ghr), 32'd0);
        check("mispred_count[0]", 32'(mispred_count[0]), 32'd6);
        check("hit_count[0] final", 32'(hit_count[0]), 32'd1);
        // Gshare: T,N,T at 0x0040 uses counters 0,1,2 and leaves ghr=00101
        upd(1, 16'h0040, 1'b0, 1'b1, 16'h0020, 1'b0, 16'h0000, 1'b1);
        upd(1, 16'h0040, 1'b0, 1'b0, 16'h0020, 1'b0, 16'h0000, 1'b0);
        upd(1, 16'h0040, 1'b0, 1'b1, 16'h0020, 1'b0, 16'h0000, 1'b1);
        check("ghr[1] after T,N,T", 32'(u1.r_ghr), 32'b00101);
        look(1, 16'h0040, 1'b0, 16'h0020);
        upd(1, 16'h0040, 1'b0, 1'b1, 16'h0020, 1'b0, 16'h0000, 1'b1);
        check("ctr[1][0]", 32'(u1.r_ctr[0]), 32'd2);
        check("ctr[1][1]", 32'(u1.r_ctr[1]), 32'd0);
        check("ctr[1][5]", 32'(u1.r_ctr[5]), 32'd2);
        check("ctr[1][11]", 32'(u1.r_ctr[11]), 32'd1);
        look(1, 16'h0040, 1'b0, 16'h0020);
        // Same-cycle lookup and update of 0x0004: old result now, new result after the edge
        if_pc[1] = 16'h0004;
        upd_valid[1] = 1'b1;
        upd_pc[1] = 16'h0004;
        upd_uncond[1] = 1'b1;
        upd_taken[1] = 1'b1;
        upd_target[1] = 16'h0600;
        upd_pred_taken[1] = 1'b0;
        upd_pred_target[1] = 16'h0000;
        #1;
        check("same-cycle pred_taken old", 32'(pred_taken[1]), 32'd0);
        check("same-cycle pred_target old", 32'(pred_target[1]), 32'h0000);
        check("same-cycle mispredict", 32'(mispredict[1]), 32'd1);
        @(posedge clk);
        #1;
        upd_valid[1] = 1'b0;
        check("next-cycle pred_taken new", 32'(pred_taken[1]), 32'd1);
        check("next-cycle pred_target new", 32'(pred_target[1]), 32'h0600);
        if_pc[1] = NEUTRAL;
        check("ghr[1] unchanged by uncond", 32'(u1.r_ghr), 32'b01011);
        check("mispred_count[1]", 32'(mispred_count[1]), 32'd4);
        check("hit_count[1]", 32'(hit_count[1]), 32'd0);
        // Asynchronous reset mid-cycle clears state before the next edge
        #2;
        rst_n = 1'b0;
        if_pc[0] = 16'h0080;
        if_pc[1] = 16'h0004;
        upd_valid[0] = 1'b1;
        upd_taken[0] = 1'b1;
        upd_pred_taken[0] = 1'b0;
        #1;
        check("reset pred_taken[0]", 32'(pred_taken[0]), 32'd0);
        check("reset pred_target[0]", 32'(pred_target[0]), 32'h0000);
        check("reset pred_taken[1]", 32'(pred_taken[1]), 32'd0);
        check("reset hit_count[0]", 32'(hit_count[0]), 32'd0);
        check("reset mispred_count[0]", 32'(mispred_count[0]), 32'd0);
        check("reset mispred_count[1]", 32'(mispred_count[1]), 32'd0);
        check("reset ghr[1]", 32'(u1.r_ghr), 32'd0);
        check("reset ctr[0][0]", 32'(u0.r_ctr[0]), 32'd1);
        check("reset mispredict comb", 32'(mispredict[0]), 32'd1);
        upd_valid[0] = 1'b0;
        if_pc[0] = NEUTRAL;
        if_pc[1] = NEUTRAL;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        look(0, 16'h0080, 1'b0, 16'h0000);
        look(1, 16'h0004, 1'b0, 16'h0000);
        check("post-reset mispred_count[0]", 32'(mispred_count[0]), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
